host_wg_dispatch: RTL

HOST_WG_DISPATCH -- requirements
Module: host_wg_dispatch

---
 rtl/host_wg_dispatch.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/host_wg_dispatch.sv
// Host-side workgroup dispatcher: issues num_wg WG requests for a kernel launch,
// bounds the number of outstanding WGs, and pulses done once all have completed.
module host_wg_dispatch #(
    parameter int WG_ID_W      = 32,
    parameter int WF_CNT_W     = 4,
    parameter int ADDR_W       = 32,
    parameter int MAX_INFLIGHT = 8
) (
    input  logic                                clk,
    input  logic                                rst_n,

    input  logic                                knl_start_i,
    output logic                                knl_busy_o,
    output logic                                knl_done_o,
    input  logic [WG_ID_W-1:0]                  knl_num_wg_i,
    input  logic [WG_ID_W-1:0]                  knl_wg_id_base_i,
    input  logic [WF_CNT_W-1:0]                 knl_num_wf_i,
    input  logic [ADDR_W-1:0]                   knl_start_pc_i,
    input  logic [ADDR_W-1:0]                   knl_csr_knl_i,
    input  logic [ADDR_W-1:0]                   knl_pds_base_i,
    input  logic [ADDR_W-1:0]                   knl_pds_stride_i,

    output logic                                host_req_valid_o,
    input  logic                                host_req_ready_i,
    output logic [WG_ID_W-1:0]                  host_req_wg_id_o,
    output logic [WF_CNT_W-1:0]                 host_req_num_wf_o,
    output logic [ADDR_W-1:0]                   host_req_start_pc_o,
    output logic [ADDR_W-1:0]                   host_req_pds_baseaddr_o,
    output logic [ADDR_W-1:0]                   host_req_csr_knl_o,

    input  logic                                host_rsp_valid_i,
    output logic                                host_rsp_ready_o,
    input  logic [WG_ID_W-1:0]                  host_rsp_wg_id_i,

    output logic [$clog2(MAX_INFLIGHT+1)-1:0]   inflight_o,
    output logic                                err_o
);

    localparam int IFL_W = $clog2(MAX_INFLIGHT + 1);
    localparam logic [IFL_W-1:0] MAX_CNT = IFL_W'(MAX_INFLIGHT);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t                state_q, state_d;
    logic [WG_ID_W-1:0]    num_wg_q, wg_id_base_q, issued_q, issued_inc;
    logic [WF_CNT_W-1:0]   num_wf_q;
    logic [ADDR_W-1:0]     start_pc_q, csr_knl_q, pds_stride_q, pds_acc_q;
    logic [IFL_W-1:0]      inflight_q;
    logic                  err_q;
    logic                  start_acc, req_valid, rsp_ready, req_hs, rsp_hs;

    // Completion IDs are not checked against issued IDs; only the count matters.
    logic unused_rsp_id;
    assign unused_rsp_id = ^host_rsp_wg_id_i;

    assign issued_inc = issued_q + 1'b1;
    assign start_acc  = (state_q == IDLE) && knl_start_i;
    assign req_hs     = req_valid && host_req_ready_i;
    assign rsp_hs     = rsp_ready && host_rsp_valid_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        req_valid  = 1'b0;
        rsp_ready  = 1'b0;
        knl_busy_o = 1'b1;
        knl_done_o = 1'b0;
        case (state_q)
            IDLE: begin
                knl_busy_o = 1'b0;
                if (knl_start_i)
                    state_d = (knl_num_wg_i == '0) ? DONE : ISSUE;
            end
            ISSUE: begin
                rsp_ready = 1'b1;
                req_valid = (issued_q < num_wg_q) && (inflight_q < MAX_CNT);
                if (req_valid && host_req_ready_i && (issued_inc == num_wg_q))
                    state_d = DRAIN;
            end
            DRAIN: begin
                rsp_ready = 1'b1;
                if (inflight_q == '0)
                    state_d = DONE;
            end
            DONE: begin
                knl_done_o = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            num_wg_q     <= '0;
            wg_id_base_q <= '0;
            num_wf_q     <= '0;
            start_pc_q   <= '0;
            csr_knl_q    <= '0;
            pds_stride_q <= '0;
            pds_acc_q    <= '0;
            issued_q     <= '0;
            inflight_q   <= '0;
            err_q        <= 1'b0;
        end else if (start_acc) begin
            num_wg_q     <= knl_num_wg_i;
            wg_id_base_q <= knl_wg_id_base_i;
            num_wf_q     <= knl_num_wf_i;
            start_pc_q   <= knl_start_pc_i;
            csr_knl_q    <= knl_csr_knl_i;
            pds_stride_q <= knl_pds_stride_i;
            pds_acc_q    <= knl_pds_base_i;
            issued_q     <= '0;
            inflight_q   <= '0;
            err_q        <= 1'b0;
        end else begin
            // PDS address is accumulated per issue instead of multiplied out.
            if (req_hs) begin
                issued_q  <= issued_inc;
                pds_acc_q <= pds_acc_q + pds_stride_q;
            end
            if (req_hs && !rsp_hs)
                inflight_q <= inflight_q + 1'b1;
            else if (rsp_hs && !req_hs) begin
                if (inflight_q == '0) err_q      <= 1'b1;
                else                  inflight_q <= inflight_q - 1'b1;
            end
        end
    end

    assign host_req_valid_o        = req_valid;
    assign host_rsp_ready_o        = rsp_ready;
    assign host_req_wg_id_o        = wg_id_base_q + issued_q;
    assign host_req_num_wf_o       = num_wf_q;
    assign host_req_start_pc_o     = start_pc_q;
    assign host_req_csr_knl_o      = csr_knl_q;
    assign host_req_pds_baseaddr_o = pds_acc_q;
    assign inflight_o              = inflight_q;
    assign err_o                   = err_q;

endmodule
